// File: rtl/game_ctrl_pkg.sv
// Shared types and defaults for the Life step sequencer.
//   ctrl_state_t     : sequencer state encoding
//   SPEED_WIDTH_DEF  : default width of the speed select
//   GEN_WIDTH_DEF    : default width of the generation counter
//   NET_DEFAULT      : grid overlay state after reset
//   frame_cnt_width  : frame counter width able to hold 2**(2**sw-1)-1
package game_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_PAUSED     = 2'd0,
      ST_RUN_WAIT   = 2'd1,
      ST_STEP_BUSY  = 2'd2,
      ST_CLEAR_BUSY = 2'd3
   } ctrl_state_t;

   localparam int unsigned SPEED_WIDTH_DEF = 3;
   localparam int unsigned GEN_WIDTH_DEF   = 16;
   localparam logic        NET_DEFAULT     = 1'b1;

   // Largest speed value is 2**sw-1, so the reload value needs that many bits.
   function automatic int unsigned frame_cnt_width(input int unsigned sw);
      return (32'd1 << sw) - 32'd1;
   endfunction

endpackage

// File: rtl/game_frame_divider.sv
// Frames-per-generation down-counter.
//   clk, rst_n : clock, async active-low reset
//   load_i     : reload with 2**speed_i - 1
//   dec_i      : decrement request (a frame boundary)
//   stall_i    : hold the count while a step is outstanding
//   speed_i    : rate select, only looked at on reload
//   zero_c_o   : count has reached zero (combinational)
module game_frame_divider
   import game_ctrl_pkg::*;
#(
   parameter int unsigned SPEED_WIDTH = SPEED_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_i,
   input  logic                   dec_i,
   input  logic                   stall_i,
   input  logic [SPEED_WIDTH-1:0] speed_i,
   output logic                   zero_c_o
);

   localparam int unsigned CNT_W = frame_cnt_width(SPEED_WIDTH);
   localparam int unsigned POW_W = CNT_W + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [POW_W-1:0] pow;

   // Reload wins over decrement; the count never underflows.
   always_comb begin
      pow   = POW_W'(1) << speed_i;
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(pow - POW_W'(1));
      end else if (dec_i && !stall_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/game_step_ctrl.sv
// Run/pause sequencer for the 40x30 Life field. Launches generation steps
// only at frame boundaries and handshakes step/clear with the update engine.
// Optional: define GAME_STEP_CTRL_GEN_LIMIT_EN to auto-pause at GEN_LIMIT
// generations and expose gen_limit_hit.
//   clk, rst            : clock, async active-low reset
//   frame_start         : start-of-frame pulse
//   btn_run/step/clear/net : debounced button pulses
//   speed               : frames per generation = 2**speed
//   step_ack, clear_ack : engine completion pulses
//   step_req, clear_req : engine requests, held until ack
//   running             : auto-run mode indicator
//   enable_net          : grid overlay enable
//   gen_count           : generations since reset/clear
//   overrun             : sticky, frame boundary seen with a step outstanding
module game_step_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int unsigned SPEED_WIDTH = SPEED_WIDTH_DEF,
`ifdef GAME_STEP_CTRL_GEN_LIMIT_EN
   parameter int unsigned GEN_LIMIT   = 1000,
`endif
   parameter int unsigned GEN_WIDTH   = GEN_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   frame_start,
   input  logic                   btn_run,
   input  logic                   btn_step,
   input  logic                   btn_clear,
   input  logic                   btn_net,
   input  logic [SPEED_WIDTH-1:0] speed,
   input  logic                   step_ack,
   input  logic                   clear_ack,
   output logic                   step_req,
   output logic                   clear_req,
   output logic                   running,
   output logic                   enable_net,
   output logic [GEN_WIDTH-1:0]   gen_count,
`ifdef GAME_STEP_CTRL_GEN_LIMIT_EN
   output logic                   gen_limit_hit,
`endif
   output logic                   overrun
);

   ctrl_state_t          state_q, state_d;
   logic                 resume_q, resume_d;       // 1 = return to RUN_WAIT
   logic                 pend_run_q, pend_run_d;
   logic                 pend_clear_q, pend_clear_d;
   logic                 step_req_q, step_req_d;
   logic                 clear_req_q, clear_req_d;
   logic                 running_q, running_d;
   logic                 net_q, net_d;
   logic                 overrun_q, overrun_d;
   logic [GEN_WIDTH-1:0] gen_q, gen_d;
   logic                 cnt_load, cnt_dec, cnt_zero_c;
   logic                 run_ok_c;
   logic                 res_c, hit_c;
`ifdef GAME_STEP_CTRL_GEN_LIMIT_EN
   logic                 limit_q, limit_d;
   assign run_ok_c = btn_run & ~limit_q;
`else
   assign run_ok_c = btn_run;
`endif

   game_frame_divider #(
      .SPEED_WIDTH (SPEED_WIDTH)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst),
      .load_i   (cnt_load),
      .dec_i    (cnt_dec),
      .stall_i  (step_req_q),
      .speed_i  (speed),
      .zero_c_o (cnt_zero_c)
   );

   // Next-state and output decode.
   always_comb begin
      state_d      = state_q;
      resume_d     = resume_q;
      pend_run_d   = pend_run_q;
      pend_clear_d = pend_clear_q;
      step_req_d   = step_req_q;
      clear_req_d  = clear_req_q;
      gen_d        = gen_q;
      overrun_d    = overrun_q | (frame_start & step_req_q);
      net_d        = net_q ^ btn_net;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      res_c        = resume_q;
      hit_c        = 1'b0;
`ifdef GAME_STEP_CTRL_GEN_LIMIT_EN
      limit_d      = limit_q;
`endif

      case (state_q)
         ST_PAUSED: begin
            if (btn_clear) begin
               state_d     = ST_CLEAR_BUSY;
               clear_req_d = 1'b1;
               resume_d    = 1'b0;
            end else if (run_ok_c) begin
               state_d  = ST_RUN_WAIT;
               cnt_load = 1'b1;
               resume_d = 1'b1;
            end else if (btn_step) begin
               // step_req waits for the next frame boundary
               state_d  = ST_STEP_BUSY;
               resume_d = 1'b0;
            end
         end

         ST_RUN_WAIT: begin
            if (btn_clear) begin
               state_d     = ST_CLEAR_BUSY;
               clear_req_d = 1'b1;
               resume_d    = 1'b1;
            end else if (run_ok_c) begin
               state_d  = ST_PAUSED;
               resume_d = 1'b0;
            end else if (frame_start) begin
               if (cnt_zero_c) begin
                  state_d    = ST_STEP_BUSY;
                  step_req_d = 1'b1;
                  resume_d   = 1'b1;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end

         ST_STEP_BUSY: begin
            pend_clear_d = pend_clear_q | btn_clear;
            pend_run_d   = pend_run_q | run_ok_c;
            if (!step_req_q && frame_start) begin
               step_req_d = 1'b1;
            end
            if (step_req_q && step_ack) begin
               step_req_d   = 1'b0;
               gen_d        = gen_q + GEN_WIDTH'(1);
               cnt_load     = 1'b1;
               pend_run_d   = 1'b0;
               pend_clear_d = 1'b0;
`ifdef GAME_STEP_CTRL_GEN_LIMIT_EN
               if (gen_d == GEN_WIDTH'(GEN_LIMIT)) begin
                  res_c   = 1'b0;
                  hit_c   = 1'b1;
                  limit_d = 1'b1;
               end
`endif
               // Pending buttons apply now; clear beats run.
               if (pend_clear_q | btn_clear) begin
                  state_d     = ST_CLEAR_BUSY;
                  clear_req_d = 1'b1;
                  resume_d    = res_c;
               end else if ((pend_run_q | run_ok_c) & ~hit_c) begin
                  state_d  = res_c ? ST_PAUSED : ST_RUN_WAIT;
                  resume_d = ~res_c;
               end else begin
                  state_d  = res_c ? ST_RUN_WAIT : ST_PAUSED;
                  resume_d = res_c;
               end
            end
         end

         ST_CLEAR_BUSY: begin
            pend_run_d = pend_run_q | btn_run;
            if (clear_req_q && clear_ack) begin
               clear_req_d  = 1'b0;
               gen_d        = '0;
               overrun_d    = 1'b0;
               pend_run_d   = 1'b0;
               pend_clear_d = 1'b0;
`ifdef GAME_STEP_CTRL_GEN_LIMIT_EN
               limit_d      = 1'b0;
`endif
               if (pend_run_q | btn_run) begin
                  state_d  = ST_RUN_WAIT;
                  cnt_load = 1'b1;
                  resume_d = 1'b1;
               end else begin
                  state_d  = ST_PAUSED;
                  resume_d = 1'b0;
               end
            end
         end

         default: begin
            state_d = ST_PAUSED;
         end
      endcase

      running_d = (state_d == ST_RUN_WAIT) |
                  (((state_d == ST_STEP_BUSY) | (state_d == ST_CLEAR_BUSY)) & resume_d);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_PAUSED;
         resume_q     <= 1'b0;
         pend_run_q   <= 1'b0;
         pend_clear_q <= 1'b0;
         step_req_q   <= 1'b0;
         clear_req_q  <= 1'b0;
         running_q    <= 1'b0;
         net_q        <= NET_DEFAULT;
         overrun_q    <= 1'b0;
         gen_q        <= '0;
`ifdef GAME_STEP_CTRL_GEN_LIMIT_EN
         limit_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         resume_q     <= resume_d;
         pend_run_q   <= pend_run_d;
         pend_clear_q <= pend_clear_d;
         step_req_q   <= step_req_d;
         clear_req_q  <= clear_req_d;
         running_q    <= running_d;
         net_q        <= net_d;
         overrun_q    <= overrun_d;
         gen_q        <= gen_d;
`ifdef GAME_STEP_CTRL_GEN_LIMIT_EN
         limit_q      <= limit_d;
`endif
      end
   end

   assign step_req   = step_req_q;
   assign clear_req  = clear_req_q;
   assign running    = running_q;
   assign enable_net = net_q;
   assign gen_count  = gen_q;
   assign overrun    = overrun_q;
`ifdef GAME_STEP_CTRL_GEN_LIMIT_EN
   assign gen_limit_hit = limit_q;
`endif

endmodule

// File: tb/tb_game_step_ctrl.sv
// Scoreboard bench for game_step_ctrl: stimulus queues the expected request
// rises (kind, cycle, gen_count at rise); a monitor pops them as they occur.
module tb_game_step_ctrl;

   localparam int B_RUN = 0;
   localparam int B_STEP = 1;
   localparam int B_CLR = 2;
   localparam int B_NET = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic        btn_run = 1'b0, btn_step = 1'b0, btn_clear = 1'b0, btn_net = 1'b0;
   logic [2:0]  speed = 3'd0;
   logic        eng_step_ack = 1'b0, man_step_ack = 1'b0, clear_ack = 1'b0;
   logic        step_ack;
   logic        step_req, clear_req, running, enable_net, overrun;
   logic [15:0] gen_count;
`ifdef GAME_STEP_CTRL_GEN_LIMIT_EN
   logic        gen_limit_hit;
`endif

   assign step_ack = eng_step_ack | man_step_ack;

   game_step_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .btn_run     (btn_run),
      .btn_step    (btn_step),
      .btn_clear   (btn_clear),
      .btn_net     (btn_net),
      .speed       (speed),
      .step_ack    (step_ack),
      .clear_ack   (clear_ack),
      .step_req    (step_req),
      .clear_req   (clear_req),
      .running     (running),
      .enable_net  (enable_net),
      .gen_count   (gen_count),
`ifdef GAME_STEP_CTRL_GEN_LIMIT_EN
      .gen_limit_hit (gen_limit_hit),
`endif
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;   // 0 = step_req rise, 1 = clear_req rise
      int cyc;    // expected cycle of the rise, -1 = don't care
      int gen;    // gen_count expected when the rise is seen
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   ack_en = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic see_req(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL req_unexpected: got rise of kind %0d expected none (cyc=%0d)", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         chk("req_kind", kind, e.kind);
         if (e.cyc >= 0) chk("req_cycle", cyc, e.cyc);
         chk("req_gen", gen_count, e.gen);
      end
   endtask

   // Monitor: compare each request rise against the scoreboard head.
   logic prev_step = 1'b0, prev_clr = 1'b0;
   always @(negedge clk) begin
      if (step_req && !prev_step) see_req(0);
      if (clear_req && !prev_clr) see_req(1);
      prev_step = step_req;
      prev_clr  = clear_req;
   end

   // Engine model: ack 10 cycles after a request is seen.
   initial begin
      forever begin
         @(negedge clk);
         if (ack_en && step_req) begin
            repeat (10) @(posedge clk);
            #1 eng_step_ack = 1'b1;
            @(posedge clk);
            #1 eng_step_ack = 1'b0;
         end else if (ack_en && clear_req) begin
            repeat (10) @(posedge clk);
            #1 clear_ack = 1'b1;
            @(posedge clk);
            #1 clear_ack = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout at %0t expected $finish earlier", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input int b);
      case (b)
         B_RUN:   btn_run   = 1'b1;
         B_STEP:  btn_step  = 1'b1;
         B_CLR:   btn_clear = 1'b1;
         default: btn_net   = 1'b1;
      endcase
      tick();
      btn_run = 1'b0; btn_step = 1'b0; btn_clear = 1'b0; btn_net = 1'b0;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic push(input int kind, input int c, input int g);
      exp_t e;
      e.kind = kind; e.cyc = c; e.gen = g;
      exp_q.push_back(e);
   endtask

   initial begin
      int sc;
      // Reset values
      #2 rst = 1'b0;
      repeat (3) tick();
      chk("rst_step_req", step_req, 0);
      chk("rst_clear_req", clear_req, 0);
      chk("rst_running", running, 0);
      chk("rst_enable_net", enable_net, 1);
      chk("rst_gen", gen_count, 0);
      chk("rst_overrun", overrun, 0);
      rst = 1'b1;
      tick();

      // Grid toggle, then run at one frame per generation
      press(B_NET);
      chk("net_toggle", enable_net, 0);
      speed = 3'd0;
      press(B_RUN);
      chk("run_on", running, 1);
      for (int i = 0; i < 5; i++) begin
         frame();
         push(0, cyc, i);
         repeat (19) tick();
      end
      chk("gen_after_5", gen_count, 5);
      chk("still_running", running, 1);
      press(B_RUN);
      chk("paused", running, 0);

      // Clear from pause
      press(B_CLR);
      push(1, cyc, 5);
      repeat (20) tick();
      chk("gen_after_clear", gen_count, 0);
      chk("clear_req_low", clear_req, 0);

      // Four frames per generation
      speed = 3'd2;
      press(B_RUN);
      for (int i = 1; i <= 12; i++) begin
         frame();
         if ((i % 4) == 0) push(0, cyc, (i / 4) - 1);
         repeat (19) tick();
      end
      chk("gen_speed2", gen_count, 3);
      press(B_RUN);
      chk("paused2", running, 0);

      // Single step waits for a frame; second step press dropped
      press(B_STEP);
      repeat (3) tick();
      chk("step_waits_frame", step_req, 0);
      chk("step_not_running", running, 0);
      press(B_STEP);
      repeat (2) tick();
      frame();
      push(0, cyc, 3);
      repeat (20) tick();
      chk("gen_single", gen_count, 4);
      chk("single_paused", running, 0);
      frame();
      repeat (5) tick();
      chk("no_extra_step", step_req, 0);
      chk("gen_single_hold", gen_count, 4);

      // Overrun: engine stalls across two frames
      speed = 3'd0;
      ack_en = 1'b0;
      press(B_RUN);
      frame();
      push(0, cyc, 4);
      repeat (5) tick();
      chk("overrun_clean", overrun, 0);
      frame();
      repeat (5) tick();
      frame();
      repeat (2) tick();
      chk("overrun_set", overrun, 1);
      chk("step_held", step_req, 1);
      chk("gen_stalled", gen_count, 4);
      man_step_ack = 1'b1;
      tick();
      man_step_ack = 1'b0;
      chk("step_dropped", step_req, 0);
      chk("gen_after_late_ack", gen_count, 5);
      chk("overrun_sticky", overrun, 1);
      chk("run_resumed", running, 1);
      ack_en = 1'b1;
      repeat (3) tick();

      // Clear pressed during a running step
      frame();
      sc = cyc;
      push(0, sc, 5);
      repeat (3) tick();
      press(B_CLR);
      push(1, sc + 11, 6);
      repeat (30) tick();
      chk("gen_cleared", gen_count, 0);
      chk("clear_pauses", running, 0);
      chk("overrun_cleared", overrun, 0);
      chk("clear_req_done", clear_req, 0);

      // Reset during a handshake, late ack afterwards
      ack_en = 1'b0;
      press(B_RUN);
      frame();
      push(0, cyc, 0);
      repeat (3) tick();
      rst = 1'b0;
      #1;
      chk("async_drop_step", step_req, 0);
      chk("async_running", running, 0);
      repeat (2) tick();
      chk("mid_rst_net", enable_net, 1);
      chk("mid_rst_overrun", overrun, 0);
      rst = 1'b1;
      tick();
      man_step_ack = 1'b1;
      tick();
      man_step_ack = 1'b0;
      repeat (3) tick();
      chk("late_ack_gen", gen_count, 0);
      chk("late_ack_step", step_req, 0);
      chk("late_ack_running", running, 0);
      chk("late_ack_clear", clear_req, 0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
